uart_line_rx: RTL
=================

Name: uart_line_rx

Overview:
Receive end of the board's 8N1 UART serial link, facing the transmit path that sends CR/LF-terminated ASCII/UTF-8 lines such as "Hello Tang Nano 20K\r\n".
- Deserialises rx_pin into bytes.
- Assembles bytes into a line buffer until LF.
- Presents the whole line on a packed bus with a valid/ready handshake for the downstream command or compare logic.
- Includes its own bit-level receiver; no external uart_rx instance is needed.

Parameters:
CLK_FRE, 27, system clock frequency in MHz.
BAUD_RATE, 115200, serial bit rate in bit/s.
MAX_LEN, 32, maximum stored bytes per line (1..255).

Ports:
clock  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_pin  input  1  asynchronous serial input; idles high.
line_data  output  MAX_LEN*8  line bytes; first byte in [MAX_LEN*8-1 -: 8], unused bytes zero.
line_len  output  8  number of valid bytes in line_data (1..MAX_LEN).
line_valid  output  1  line available; held until accepted.
line_ready  input  1  consumer accepts the line when high together with line_valid.
frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
overflow  output  1  one-cycle pulse when a received byte is discarded.

Behaviour:
- Reset (synchronous, active-high)
  - line_data=0, line_len=0, line_valid=0, frame_err=0, overflow=0.
  - Receiver returns to IDLE, byte count=0, synchroniser flops set to 1.
  - Reset in mid-frame or mid-line discards everything.
- Timing
  - CYCLES = CLK_FRE*1000000/BAUD_RATE, integer-truncated; 234 at defaults.
  - HALF = CYCLES/2 = 117.
- Input: rx_pin passes through a 2-flop synchroniser; only the synchronised signal is used.
- Bit FSM
  - IDLE: a high-to-low transition on the synchronised input starts the frame → START, bit counter cleared.
  - START: count HALF cycles, then sample. Low → DATA. High → treat as a glitch → IDLE, no error.
  - DATA: sample every CYCLES cycles, 8 samples, LSB first into a shift register → STOP.
  - STOP: sample after CYCLES cycles.
    - High → byte complete; emit an internal 1-cycle byte strobe → IDLE.
    - Low → frame_err pulse, byte dropped → BREAK.
  - BREAK: wait until the synchronised input is high → IDLE.
- Line assembly, acting on each byte strobe
  - 0x0D: ignored, never stored.
  - 0x0A with count>0: line_valid<=1 on the next clock, line_len<=count. line_data is already in place.
  - 0x0A with count=0: empty line, ignored; line_valid stays 0.
  - Any other byte with count<MAX_LEN: stored at byte index count (MSB-first packing), count<=count+1.
  - Any other byte with count=MAX_LEN: dropped, overflow pulse. A later LF still terminates the line with line_len=MAX_LEN.
  - Any byte while line_valid=1: dropped, overflow pulse. This includes a byte whose strobe coincides with the accepting handshake cycle.
- Handshake
  - Transfer occurs when line_valid && line_ready on a rising edge.
  - Next cycle: line_valid=0, line_data=0, line_len=0, count=0.
  - line_data and line_len stay stable while line_valid=1 && line_ready=0.
  - line_ready while line_valid=0 has no effect.
- Latency
  - Stop-bit sample of the LF → line_valid high exactly 2 clocks later: 1 for the strobe, 1 for the register.
  - Start edge on the pin → START entry = 2 synchroniser cycles + 1.
- frame_err and overflow are never asserted in the same cycle as each other's cause being ignored; each event produces exactly one pulse.

Test Plan:
1. Send "Hello Tang Nano 20K\r\n" at 115200, CLK_FRE=27, line_ready=1.
   → one line_valid pulse, line_len=19, top 19 bytes = "Hello Tang Nano 20K", rest 0, no error pulses.
2. Send the UTF-8 bytes E4 BD A0 E5 A5 BD then 0A.
   → line_len=6, bytes in order, CR absent.
3. Send 40 'A' (0x41) then LF with MAX_LEN=32.
   → 8 overflow pulses, line_len=32, all 32 bytes 0x41.
4. Hold line_ready=0, send "AB\n" then "CD\n".
   → line "AB" (len 2) held stable, 3 overflow pulses for C, D and LF. Raise line_ready → line_valid drops next cycle. Then send "EF\n" → line_len=2, "EF".
5. Send a frame with the stop bit low (0x55, stop=0), then "X\n".
   → exactly one frame_err pulse, next line_len=1, data 0x58.
6. Drive a 50-cycle low glitch on rx_pin.
   → no byte, no pulses. Assert reset mid-byte of "Q\n", release, send "Z\n" → line_len=1, data 0x5A.

Source files
------------

// File: rtl/uart_line_rx.sv
// 8N1 serial receiver that assembles CR/LF-terminated text lines and hands
// each complete line downstream over a valid/ready handshake.
module uart_line_rx #(
  parameter int CLK_FRE   = 27,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_LEN   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_pin,
  output logic [MAX_LEN*8-1:0] line_data,
  output logic [7:0]           line_len,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int              CYCLES    = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int              HALF      = CYCLES / 2;
  localparam logic [15:0]     BIT_LAST  = 16'(CYCLES - 1);
  localparam logic [15:0]     HALF_LAST = 16'(HALF - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Bit-level receiver state
  logic        sync1_q, sync2_q, prev_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        strobe_q, strobe_d;
  logic        frame_err_q, frame_err_d;

  // Line assembly state
  logic [MAX_LEN*8-1:0] line_data_q, line_data_d;
  logic [7:0]           line_len_q, line_len_d;
  logic                 line_valid_q, line_valid_d;
  logic [7:0]           count_q, count_d;
  logic                 overflow_q, overflow_d;

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      strobe_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      // NOTE: line_data is a plain register bank, not a RAM, so it can and
      // must be cleared because unused bytes are required to read as zero.
      line_data_q  <= '0;
      line_len_q   <= '0;
      line_valid_q <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= rx_pin;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_byte_q    <= rx_byte_d;
      strobe_q     <= strobe_d;
      frame_err_q  <= frame_err_d;
      line_data_q  <= line_data_d;
      line_len_q   <= line_len_d;
      line_valid_q <= line_valid_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    strobe_d    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A start bit that is gone by mid-bit was noise, not a frame
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            rx_byte_d = shift_q;
            strobe_d  = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    line_data_d  = line_data_q;
    line_len_d   = line_len_q;
    line_valid_d = line_valid_q;
    count_d      = count_q;
    overflow_d   = 1'b0;

    if (line_valid_q && line_ready) begin
      line_valid_d = 1'b0;
      line_data_d  = '0;
      line_len_d   = '0;
      count_d      = '0;
    end

    // A pending line blocks new bytes, even on the cycle it is accepted
    if (strobe_q) begin
      if (line_valid_q) begin
        overflow_d = 1'b1;
      end else if (rx_byte_q == 8'h0A) begin
        if (count_q != 8'd0) begin
          line_valid_d = 1'b1;
          line_len_d   = count_q;
        end
      end else if (rx_byte_q != 8'h0D) begin
        if (count_q < MAX_LEN_B) begin
          line_data_d[(MAX_LEN - 1 - int'(count_q)) * 8 +: 8] = rx_byte_q;
          count_d = count_q + 8'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  assign line_data  = line_data_q;
  assign line_len   = line_len_q;
  assign line_valid = line_valid_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
